// File: rtl/capture_ctrl.sv
// Capture-RAM write controller: decimated sampling, pre/post-trigger framing, auto-roll.
// Optional macro TRIG_SYNC_EN adds a two-flop synchronizer on trig1/trig2.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig1,
  input  logic              trig2,
  input  logic [7:0]        trig_cfg,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [3:0]        decimator,
  input  logic              capture_start,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              cap_done
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, POST, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_P = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [14:0]       div_cnt;
  logic [14:0]       div_max;
  logic              sample_en;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] wptr_nxt;
  logic [ADDR_W:0]   post_rem;
  logic [ADDR_W:0]   post_full;
  logic              t1, t2;
  logic              prev1, prev2;
  logic              cur, prv, chan_ok;
  logic              evt, fire, type_ok, auto_roll;
  logic              unused_cfg;

`ifdef TRIG_SYNC_EN
  logic [1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {sync1[0], trig1};
      sync2 <= {sync2[0], trig2};
    end
  end

  assign t1 = sync1[1];
  assign t2 = sync2[1];
`else
  assign t1 = trig1;
  assign t2 = trig2;
`endif

  assign unused_cfg = ^trig_cfg[7:5];
  assign div_max    = 15'((16'd1 << decimator) - 16'd1);
  assign sample_en  = (div_cnt == div_max);
  assign wptr_nxt   = wptr + ONE_A;
  assign post_full  = DEPTH - {1'b0, trig_pos};
  assign type_ok    = (trig_cfg[3:2] == 2'b01) || (trig_cfg[3:2] == 2'b10);
  assign auto_roll  = (trig_cfg[3:2] == 2'b10);

  always_comb begin
    cur     = 1'b0;
    prv     = 1'b0;
    chan_ok = 1'b0;
    case (trig_cfg[1:0])
      2'b00: begin cur = t1; prv = prev1; chan_ok = 1'b1; end
      2'b01: begin cur = t2; prv = prev2; chan_ok = 1'b1; end
      default: ;
    endcase
  end

  assign evt  = chan_ok && (trig_cfg[4] ? (cur & ~prv) : (~cur & prv));
  // Auto-roll fires on the first sample taken while waiting, ignoring the inputs
  assign fire = auto_roll ? sample_en : evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we        <= 1'b0;
      waddr     <= '0;
      trig_addr <= '0;
      armed     <= 1'b0;
      cap_done  <= 1'b0;
      wptr      <= '0;
      div_cnt   <= '0;
      post_rem  <= '0;
      prev1     <= 1'b0;
      prev2     <= 1'b0;
    end else begin
      we    <= 1'b0;
      prev1 <= t1;
      prev2 <= t2;
      if (capture_start || sample_en) div_cnt <= '0;
      else                            div_cnt <= div_cnt + 15'd1;

      if (capture_start && type_ok) begin
        state    <= (trig_pos == '0) ? WAIT_TRIG : ARM;
        wptr     <= '0;
        post_rem <= '0;
        cap_done <= 1'b0;
        armed    <= 1'b1;
      end else begin
        case (state)
          ARM: begin
            if (sample_en) begin
              we    <= 1'b1;
              waddr <= wptr;
              wptr  <= wptr_nxt;
              if (wptr_nxt == trig_pos) state <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (sample_en) begin
              we    <= 1'b1;
              waddr <= wptr;
              wptr  <= wptr_nxt;
            end
            if (fire) begin
              trig_addr <= wptr;
              // A coincident sample is already the first post-trigger sample
              if (sample_en && post_full == ONE_P) begin
                state    <= DONE;
                armed    <= 1'b0;
                cap_done <= 1'b1;
              end else begin
                state    <= POST;
                post_rem <= sample_en ? post_full - ONE_P : post_full;
              end
            end
          end
          POST: begin
            if (sample_en) begin
              we       <= 1'b1;
              waddr    <= wptr;
              wptr     <= wptr_nxt;
              post_rem <= post_rem - ONE_P;
              if (post_rem == ONE_P) begin
                state    <= DONE;
                armed    <= 1'b0;
                cap_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected writes are queued by the stimulus and
// consumed by a monitor on every we pulse.
module tb_capture_ctrl;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n, trig1, trig2, capture_start;
  logic [7:0]        trig_cfg;
  logic [ADDR_W-1:0] trig_pos;
  logic [3:0]        decimator;
  logic              we, armed, cap_done;
  logic [ADDR_W-1:0] waddr, trig_addr;

  typedef struct {
    int addr;
    int gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;

  always #5 clk = ~clk;

  capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .trig1(trig1), .trig2(trig2),
    .trig_cfg(trig_cfg), .trig_pos(trig_pos), .decimator(decimator),
    .capture_start(capture_start), .we(we), .waddr(waddr),
    .trig_addr(trig_addr), .armed(armed), .cap_done(cap_done)
  );

  // Monitor: every we pulse must match the head of the queue in address and spacing
  always @(negedge clk) begin
    cyc++;
    if (we === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_we: waddr=%0d, no write expected", waddr);
      end else begin
        mon_e = sb.pop_front();
        if (waddr !== 9'(mon_e.addr)) begin
          n_fail++;
          $display("FAIL waddr: got %0d, expected %0d", waddr, mon_e.addr);
        end
        if (mon_e.gap != 0) begin
          n_tests++;
          if (cyc - last_we_cyc != mon_e.gap) begin
            n_fail++;
            $display("FAIL we_spacing: got %0d clocks, expected %0d", cyc - last_we_cyc, mon_e.gap);
          end
        end
      end
      last_we_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_seq(input int first, input int count, input int gap);
    for (int i = 0; i < count; i++)
      sb.push_back('{addr: (first + i) % DEPTH, gap: (i == 0) ? 0 : gap});
  endtask

  task automatic push_one(input int addr, input int gap);
    sb.push_back('{addr: addr, gap: gap});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (cap_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("cap_done_reached", 32'(cap_done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; trig1 = 1'b0; trig2 = 1'b0; capture_start = 1'b0;
    trig_cfg = 8'h00; trig_pos = '0; decimator = 4'd0;

    // Reset held 4 clocks with trig1 toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trig1 = ~trig1;
    end
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_cap_done", 32'(cap_done), 32'd0);
    trig1 = 1'b0;
    rst_n = 1'b1;
    cycles(2);

    // Normal, rising trig1 after 10 samples, 4 pre-trigger
    decimator = 4'd0; trig_pos = 9'd4; trig_cfg = 8'h14;
    push_seq(0, 518, 1);
    start_pulse();
    check("n_armed_after_start", 32'(armed), 32'd1);
    cycles(10);
    trig1 = 1'b1;
    wait_done(700);
    check("n_trig_addr", 32'(trig_addr), 32'd10);
    check("n_armed_done", 32'(armed), 32'd0);
    cycles(1);
    check("n_we_in_done", 32'(we), 32'd0);
    check("n_last_waddr", 32'(waddr), 32'd5);

    // Auto-roll with no pre-trigger
    trig_cfg = 8'h08; trig_pos = '0;
    push_seq(0, 512, 1);
    start_pulse();
    check("ar_cap_done_cleared", 32'(cap_done), 32'd0);
    check("ar_armed", 32'(armed), 32'd1);
    wait_done(700);
    check("ar_trig_addr", 32'(trig_addr), 32'd0);

    // Start with type off must be ignored
    trig_cfg = 8'h00;
    start_pulse();
    cycles(20);
    check("off00_armed", 32'(armed), 32'd0);
    check("off00_cap_done", 32'(cap_done), 32'd1);
    trig_cfg = 8'h0C;
    start_pulse();
    cycles(20);
    check("off11_armed", 32'(armed), 32'd0);

    // Wrap past 511, falling edge on trig2
    trig2 = 1'b1;
    cycles(2);
    trig_cfg = 8'h05; trig_pos = 9'd10; decimator = 4'd0;
    push_seq(0, 1102, 1);
    start_pulse();
    cycles(600);
    check("w_armed_waiting", 32'(armed), 32'd1);
    check("w_cap_done_waiting", 32'(cap_done), 32'd0);
    trig2 = 1'b0;
    wait_done(700);
    check("w_trig_addr", 32'(trig_addr), 32'd88);

    // Decimator=2, restart mid-POST, then reset mid-capture
    trig1 = 1'b0;
    cycles(2);
    decimator = 4'd2; trig_pos = 9'd2; trig_cfg = 8'h14;
    push_one(0, 0); push_one(1, 4); push_one(2, 4); push_one(3, 4);
    push_one(0, 0); push_one(1, 4); push_one(2, 4); push_one(3, 4);
    start_pulse();
    cycles(9);
    trig1 = 1'b1;
    cycles(8);
    check("d_trig_addr", 32'(trig_addr), 32'd2);
    check("d_armed_post", 32'(armed), 32'd1);
    start_pulse();
    check("rs_armed", 32'(armed), 32'd1);
    check("rs_cap_done", 32'(cap_done), 32'd0);
    cycles(17);
    rst_n = 1'b0;
    cycles(1);
    check("mr_we", 32'(we), 32'd0);
    check("mr_waddr", 32'(waddr), 32'd0);
    check("mr_trig_addr", 32'(trig_addr), 32'd0);
    check("mr_armed", 32'(armed), 32'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(30);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
